// File: rtl/buzzer_pkg.sv
// ============================================================
// buzzer_pkg : opcodes, entry field offsets and FSM states
// Rev 1.0
// ============================================================
`default_nettype none

package buzzer_pkg;

  localparam logic [7:0] c_op_nop   = 8'h00;
  localparam logic [7:0] c_op_set   = 8'h01;
  localparam logic [7:0] c_op_stop  = 8'h02;
  localparam logic [7:0] c_op_vol   = 8'h03;
  localparam logic [7:0] c_op_noise = 8'h04;
  localparam logic [7:0] c_op_peak  = 8'h05;
  localparam logic [7:0] c_op_peakl = 8'h06;

  localparam int c_dur_lsb = 16;
  localparam int c_op_lsb  = 8;
  localparam int c_arg_lsb = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  function automatic logic [23:0] make_cmd(input logic [31:0] entry);
    return {entry[c_op_lsb +: 8], 8'h00, entry[c_arg_lsb +: 8]};
  endfunction

  function automatic logic [15:0] entry_dur(input logic [31:0] entry);
    return entry[c_dur_lsb +: 16];
  endfunction

endpackage

`default_nettype wire

// File: rtl/buzzer_sequencer_if.sv
// ============================================================
// buzzer_sequencer_if : CPU push side and Buzzer16 command side
// Rev 1.0
// ============================================================
`default_nettype none

interface buzzer_sequencer_if #(
  parameter int DEPTH = 8
);
  localparam int LEVEL_W = $clog2(DEPTH + 1);

  logic               wr_en;
  logic [31:0]        wr_data;
  logic               abort;
  logic               full;
  logic [LEVEL_W-1:0] level;
  logic               overflow;
  logic               busy;
  logic               done;
  logic               cmd_start;
  logic [23:0]        cmd_out;

  modport master (
    output wr_en, wr_data, abort,
    input  full, level, overflow, busy, done, cmd_start, cmd_out
  );

  modport slave (
    input  wr_en, wr_data, abort,
    output full, level, overflow, busy, done, cmd_start, cmd_out
  );

endinterface

`default_nettype wire

// File: rtl/buzzer_fifo.sv
// ============================================================
// buzzer_fifo : register-array FIFO with combinational head read
// Rev 1.0
// ============================================================
`default_nettype none

module buzzer_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LEVEL_W-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == LEVEL_W'(DEPTH));
  assign level = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + LEVEL_W'(1);
        2'b01:   r_count <= r_count - LEVEL_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/buzzer_sequencer.sv
// ============================================================
// buzzer_sequencer : replays queued timed commands to Buzzer16
// Rev 1.0
// ============================================================
`default_nettype none

module buzzer_sequencer
  import buzzer_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int TICK_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  buzzer_sequencer_if.slave bus
);
  localparam int LEVEL_W = $clog2(DEPTH + 1);
  localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] c_pre_last = PRE_W'(TICK_DIV - 1);

  state_t             state;
  state_t             state_next;
  logic [15:0]        r_dur;
  logic [15:0]        w_dur_next;
  logic [15:0]        r_entry_dur;
  logic [PRE_W-1:0]   r_pre;
  logic [PRE_W-1:0]   w_pre_next;
  logic               r_stop_cycle;
  logic               r_cmd_start;
  logic [23:0]        r_cmd_out;
  logic               r_done;
  logic               r_overflow;
  logic               w_pop;
  logic               w_stop;
  logic               w_done_next;
  logic               w_empty;
  logic               w_full;
  logic [31:0]        w_head;
  logic [LEVEL_W-1:0] w_level;

  buzzer_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.wr_en & ~bus.abort),
    .pop   (w_pop),
    .flush (bus.abort),
    .din   (bus.wr_data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    w_pop       = 1'b0;
    w_stop      = 1'b0;
    w_done_next = 1'b0;
    w_dur_next  = r_dur;
    w_pre_next  = r_pre;
    if (bus.abort) begin
      // The STOP word rides through ISSUE with a flag so it never pops or signals done
      w_stop     = 1'b1;
      w_dur_next = '0;
      w_pre_next = '0;
      state_next = ISSUE;
    end else begin
      case (state)
        IDLE: begin
          if (!w_empty) begin
            w_pop      = 1'b1;
            state_next = ISSUE;
          end
        end
        ISSUE: begin
          if (r_stop_cycle) begin
            state_next = IDLE;
          end else if (r_entry_dur == '0) begin
            if (!w_empty) begin
              w_pop      = 1'b1;
              state_next = ISSUE;
            end else begin
              w_done_next = 1'b1;
              state_next  = IDLE;
            end
          end else begin
            w_dur_next = r_entry_dur;
            w_pre_next = '0;
            state_next = WAIT;
          end
        end
        WAIT: begin
          if (r_pre == c_pre_last) begin
            w_pre_next = '0;
            w_dur_next = r_dur - 16'd1;
            if (r_dur == 16'd1) begin
              if (!w_empty) begin
                w_pop      = 1'b1;
                state_next = ISSUE;
              end else begin
                w_done_next = 1'b1;
                state_next  = IDLE;
              end
            end
          end else begin
            w_pre_next = r_pre + PRE_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs are registered together with the state so cmd_start lines up with ISSUE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dur        <= '0;
      r_pre        <= '0;
      r_entry_dur  <= '0;
      r_stop_cycle <= 1'b0;
      r_cmd_start  <= 1'b0;
      r_cmd_out    <= '0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_dur        <= w_dur_next;
      r_pre        <= w_pre_next;
      r_stop_cycle <= w_stop;
      r_cmd_start  <= w_pop | w_stop;
      r_done       <= w_done_next;
      r_overflow   <= bus.wr_en & ~bus.abort & w_full & ~w_pop;
      if (w_stop) begin
        r_cmd_out   <= {c_op_stop, 16'h0000};
        r_entry_dur <= '0;
      end else if (w_pop) begin
        r_cmd_out   <= make_cmd(w_head);
        r_entry_dur <= entry_dur(w_head);
      end else begin
        r_cmd_out   <= {c_op_nop, 16'h0000};
      end
    end
  end

  assign bus.full      = w_full;
  assign bus.level     = w_level;
  assign bus.overflow  = r_overflow;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = r_done;
  assign bus.cmd_start = r_cmd_start;
  assign bus.cmd_out   = r_cmd_out;

endmodule

`default_nettype wire

// File: tb/tb_buzzer_sequencer.sv
// ============================================================
// tb_buzzer_sequencer : random and directed checks against a queue model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_buzzer_sequencer;
  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 4;

  logic clk;
  logic rst;

  buzzer_sequencer_if #(.DEPTH(DEPTH)) bus ();

  buzzer_sequencer #(
    .DEPTH    (DEPTH),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp    = 0;
  int n_bad    = 0;
  int n_starts = 0;

  // Model: queue of entries plus "on bus" / "quiet for N cycles" phases
  logic [31:0] m_q[$];
  int          m_phase;
  int          m_cur_dur;
  bit          m_is_stop;
  int          m_quiet;
  logic        exp_start;
  logic [23:0] exp_cmd;
  logic        exp_done;
  logic        exp_ovf;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_phase   = 0;
    m_cur_dur = 0;
    m_is_stop = 1'b0;
    m_quiet   = 0;
    exp_start = 1'b0;
    exp_cmd   = '0;
    exp_done  = 1'b0;
    exp_ovf   = 1'b0;
  endfunction

  function automatic void model_step(input logic we, input logic [31:0] data, input logic ab);
    bit          take;
    bit          fin;
    bit          was_full;
    logic [31:0] e;
    take      = 1'b0;
    fin       = 1'b0;
    was_full  = (m_q.size() == DEPTH);
    exp_start = 1'b0;
    exp_cmd   = '0;
    exp_done  = 1'b0;
    exp_ovf   = 1'b0;
    if (ab) begin
      m_q.delete();
      exp_start = 1'b1;
      exp_cmd   = 24'h020000;
      m_phase   = 1;
      m_is_stop = 1'b1;
      m_cur_dur = 0;
      return;
    end
    case (m_phase)
      0: take = (m_q.size() != 0);
      1: begin
        if (m_is_stop) m_phase = 0;
        else if (m_cur_dur == 0) fin = 1'b1;
        else begin
          m_quiet = m_cur_dur * TICK_DIV;
          m_phase = 2;
        end
      end
      default: begin
        m_quiet--;
        if (m_quiet == 0) fin = 1'b1;
      end
    endcase
    if (fin) begin
      if (m_q.size() != 0) take = 1'b1;
      else begin
        m_phase  = 0;
        exp_done = 1'b1;
      end
    end
    if (take) begin
      e         = m_q.pop_front();
      exp_start = 1'b1;
      exp_cmd   = {e[15:8], 8'h00, e[7:0]};
      m_cur_dur = int'(e[31:16]);
      m_is_stop = 1'b0;
      m_phase   = 1;
    end
    if (we) begin
      if (!was_full || take) m_q.push_back(data);
      else exp_ovf = 1'b1;
    end
  endfunction

  task automatic compare_outputs();
    check_value("cmd_start", 32'(bus.cmd_start), 32'(exp_start));
    check_value("cmd_out",   32'(bus.cmd_out),   32'(exp_cmd));
    check_value("done",      32'(bus.done),      32'(exp_done));
    check_value("overflow",  32'(bus.overflow),  32'(exp_ovf));
    check_value("busy",      32'(bus.busy),      32'(m_phase != 0));
    check_value("level",     32'(bus.level),     32'(m_q.size()));
    check_value("full",      32'(bus.full),      32'(m_q.size() == DEPTH));
  endtask

  task automatic cycle(input logic we, input logic [31:0] data, input logic ab);
    bus.wr_en   = we;
    bus.wr_data = data;
    bus.abort   = ab;
    @(posedge clk);
    model_step(we, data, ab);
    #1;
    if (bus.cmd_start) n_starts++;
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst         = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.abort   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_outputs();
    rst = 1'b1;

    // Single entry: start two edges after the push, 12 quiet cycles, then done
    cycle(1'b1, {16'd3, 8'h01, 8'h15}, 1'b0);
    idle(16);

    // Zero-duration entry followed immediately by a timed one
    cycle(1'b1, {16'd0, 8'h01, 8'h10}, 1'b0);
    cycle(1'b1, {16'd2, 8'h03, 8'h01}, 1'b0);
    idle(14);

    // Overflow: five D=1 pushes while a long entry waits
    cycle(1'b1, {16'd3, 8'h04, 8'h77}, 1'b0);
    idle(1);
    n_starts = 0;
    for (int i = 0; i < 5; i++) cycle(1'b1, {16'd1, 8'h01, 8'(8'h30 + i)}, 1'b0);
    idle(40);
    check_value("ovf_starts", 32'(n_starts), 32'd4);

    // Abort in the middle of a long WAIT with two entries queued
    cycle(1'b1, {16'd100, 8'h05, 8'h20}, 1'b0);
    cycle(1'b1, {16'd1, 8'h01, 8'h41}, 1'b0);
    cycle(1'b1, {16'd0, 8'h06, 8'h42}, 1'b0);
    idle(5);
    n_starts = 0;
    cycle(1'b0, 32'h0, 1'b1);
    idle(20);
    check_value("abort_starts", 32'(n_starts), 32'd1);

    // Randomized traffic with occasional aborts
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) < 30),
            {16'($urandom_range(0, 3)), 8'($urandom), 8'($urandom)},
            ($urandom_range(0, 99) < 3));
    end
    idle(60);

    // Asynchronous reset while waiting with entries queued
    cycle(1'b1, {16'd5, 8'h01, 8'h55}, 1'b0);
    cycle(1'b1, {16'd1, 8'h03, 8'h56}, 1'b0);
    cycle(1'b1, {16'd1, 8'h04, 8'h57}, 1'b0);
    idle(4);
    bus.wr_en = 1'b0;
    bus.abort = 1'b0;
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    compare_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    n_starts = 0;
    idle(12);
    check_value("post_reset_starts", 32'(n_starts), 32'd0);
    cycle(1'b1, {16'd0, 8'h02, 8'h99}, 1'b0);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/buzzer_sequencer.md
# buzzer_sequencer

Timed command sequencer placed directly upstream of the Buzzer16 tone block. A CPU-side bus pushes entries into a small FIFO; each entry holds an opcode, an argument and a duration. The block replays the entries as single-cycle Buzzer16 command words and holds each one for its programmed duration, so a tune plays without CPU timing.

## Interface
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- TICK_DIV, 50000: clock cycles per duration tick, minimum 1; 50000 gives 1 ms at 50 MHz.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  pushes wr_data into the FIFO this cycle.
- wr_data  in  32  entry: [31:16] duration in ticks, [15:8] opcode, [7:0] argument.
- abort  in  1  flushes the queue and forces a STOP command.
- full  out  1  the FIFO holds DEPTH entries.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.
- overflow  out  1  one-cycle pulse when a push is dropped.
- busy  out  1  the state is not IDLE.
- done  out  1  one-cycle pulse when the queue has drained.
- cmd_start  out  1  Buzzer16 start strobe.
- cmd_out  out  24  Buzzer16 command word: [23:16] opcode, [15:8] zero, [7:0] argument.

## Operation
- Reset (rst low) forces the following values:
  - all outputs 0;
  - FIFO empty;
  - state IDLE;
  - tick counter and duration counter 0.
- cmd_out must be 24'h0 (NOP) in every cycle where cmd_start is 0. Buzzer16 decodes its input every cycle, so no stale opcode may remain on the bus.
- FIFO rules:
  - A push when full is dropped and overflow pulses.
  - A push and a pop in the same cycle are both accepted, including when the FIFO is full.
  - Read and write pointers are log2(DEPTH) bits wide and wrap naturally.
- States:
  - IDLE: if the FIFO is not empty, pop the head and go to ISSUE.
  - ISSUE: for one cycle, cmd_start=1 and cmd_out={opcode, 8'h00, arg}.
    - If the duration D is 0: go to ISSUE again with the next entry if the FIFO is not empty, otherwise go to IDLE.
    - If D > 0: load the duration counter with D, clear the tick prescaler, go to WAIT.
  - WAIT: the prescaler counts 0..TICK_DIV-1 and each wrap decrements the duration counter.
    - On the cycle the counter reaches 0: pop and go to ISSUE if the FIFO is not empty, otherwise go to IDLE.
- done pulses in the first IDLE cycle after an ISSUE or WAIT whose exit found the FIFO empty. done does not pulse after an abort.
- Abort, in any state:
  - On the edge where abort=1, the FIFO is emptied, any WAIT is cancelled, and a wr_en in the same cycle is dropped without an overflow pulse.
  - The next cycle carries cmd_start=1 with cmd_out=24'h020000 (STOP), then the state is IDLE.
  - A second abort during that STOP cycle issues one more STOP cycle.
- Opcodes are not interpreted; any 8-bit value passes through. Durations are unsigned 16-bit.

## Timing
- Push into an empty, idle block at edge k: level=1 after edge k; state ISSUE after edge k+1; cmd_start is high in the cycle between edges k+1 and k+2.
- An entry with D>0 holds the bus quiet for exactly D*TICK_DIV cycles.
  - The next ISSUE starts D*TICK_DIV+1 cycles after the previous ISSUE cycle.
- Entries with D=0 give cmd_start high on consecutive cycles.
- full, level and busy are registered and reflect the state after the last edge.
- Only the abort-generated STOP depends on abort, and it comes one edge later.

## Structure
- Shared package buzzer_pkg holds:
  - opcode constants NOP=0, SET=1, STOP=2, VOL=3, NOISE=4, PEAK=5, PEAKL=6;
  - wr_data field offsets;
  - the state enum {IDLE, ISSUE, WAIT}.
- Sub-module buzzer_fifo:
  - register-array FIFO with a combinational head read;
  - ports: push, pop, flush, din, dout, full, empty, level.
- The top level contains the FSM, the prescaler, the duration counter and the output registers.

## Test plan
- Bench parameters: TICK_DIV=4 and DEPTH=4 for all scenarios below.
- Reset: hold rst low, then push {16'd3, 8'h01, 8'h15} and release.
  - Expect cmd_start=1 and cmd_out=24'h010015 for one cycle, 2 edges after the push.
  - Expect cmd_out=0 for the following 12 cycles, then a done pulse.
- Back-to-back: push D=0 SET 0x10, then D=2 VOL 0x01.
  - Expect starts on consecutive cycles with cmd_out 24'h010010 then 24'h030001.
  - Expect done 8 cycles later.
- Overflow: push 5 entries with D=1 while the first is still in WAIT.
  - Expect full, then one overflow pulse on the fifth push.
  - Expect exactly 4 starts in total.
- Abort mid-WAIT: start D=100 PEAK 0x20 with 2 entries queued; assert abort for one cycle.
  - Expect one STOP cycle (24'h020000), level=0, busy=0 afterwards.
  - Expect no done pulse and no further starts.
- Reset mid-operation: drop rst while in WAIT with entries queued.
  - Expect all outputs 0 immediately, without waiting for a clock edge.
  - After release, expect no command to issue until a new push.
